// File: rtl/data_mem_lsu_if.sv
// Request/response bus between a load/store requester and the data memory.
// The requester side uses the master modport; data_mem_lsu uses slave.
interface data_mem_lsu_if #(
    parameter int XLEN = 32
);
    // Request channel
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;

    // Response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with a single-outstanding load/store port.
// Little-endian word array with four byte lanes; RISC-V B/H/W/BU/HU access
// sizes; misaligned, out-of-range and illegal-funct3 requests are answered
// with rsp_err and leave memory untouched.
module data_mem_lsu #(
    parameter int XLEN      = 32,
    parameter int DMEM_SIZE = 4096
) (
    input logic          clk,
    input logic          rst,
    data_mem_lsu_if.slave bus
);
    localparam int            AW        = $clog2(DMEM_SIZE);
    localparam int            WORDS     = DMEM_SIZE / 4;
    localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(DMEM_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic            accept;
    logic [2:0]      acc_size;
    logic            f3_legal;
    logic            misaligned;
    logic            out_of_range;
    logic            req_err;
    logic [XLEN:0]   end_addr;
    logic [AW-3:0]   word_idx;
    logic [1:0]      lane;
    logic [3:0]      byte_en;
    logic [XLEN-1:0] wdata_lanes;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [XLEN-1:0] mem [WORDS];

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign word_idx = bus.req_addr[AW-1:2];
    assign lane     = bus.req_addr[1:0];

    // Decode access size and classify the request as legal or erroring.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        acc_size = 3'd1;
        f3_legal = 1'b0;
        case (bus.req_funct3)
            3'b000: begin acc_size = 3'd1; f3_legal = 1'b1;         end
            3'b001: begin acc_size = 3'd2; f3_legal = 1'b1;         end
            3'b010: begin acc_size = 3'd4; f3_legal = 1'b1;         end
            3'b100: begin acc_size = 3'd1; f3_legal = !bus.req_we;  end
            3'b101: begin acc_size = 3'd2; f3_legal = !bus.req_we;  end
            default: ;
        endcase
        misaligned   = ((acc_size == 3'd2) && lane[0]) ||
                       ((acc_size == 3'd4) && (lane != 2'b00));
        // Range check uses the full address, so upper bits beyond the array
        // only matter here and are dropped when indexing the words.
        end_addr     = {1'b0, bus.req_addr} + (XLEN+1)'(acc_size);
        out_of_range = end_addr > MEM_BYTES;
        req_err      = !f3_legal || misaligned || out_of_range;
    end

    // Steer store data onto the byte lanes selected by size and address.
    always_comb begin
        byte_en     = 4'b1111;
        wdata_lanes = bus.req_wdata;
        case (acc_size)
            3'd1: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{bus.req_wdata[7:0]}};
            end
            3'd2: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed byte/halfword from the stored word.
    always_comb begin
        rd_word = mem[word_idx];
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.req_funct3)
            3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // Commit legal stores on the accept edge; reset blocks the write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; only control and response state are cleared, so the array can map onto RAM.
        if (accept && !rst && bus.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Capture the response at the accept edge and hold it until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= req_err;
            rdata_q <= (bus.req_we || req_err) ? '0 : load_val;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vectors with literal
// expectations plus a byte-array reference model checked every cycle.
module tb_data_mem_lsu;
    localparam int DMEM_SIZE = 4096;

    logic clk;
    logic rst;

    data_mem_lsu_if #(.XLEN(32)) bus ();

    data_mem_lsu #(.XLEN(32), .DMEM_SIZE(DMEM_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain byte array plus written-flags.
    logic [7:0]  m_mem   [DMEM_SIZE];
    bit          m_known [DMEM_SIZE];
    bit          m_live    = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_unknown = 1'b0;
    logic [31:0] m_rdata   = '0;
    logic        m_err     = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] exp;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural effect of one accepted request on the byte array.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [2:0] f3, input logic [31:0] wdata);
        int          size;
        bit          legal;
        longint      a;
        logic [31:0] v;
        a = longint'(addr);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        legal     = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                    (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
        m_err     = !legal || (a % size != 0) || (a + size > DMEM_SIZE);
        m_rdata   = '0;
        m_unknown = 1'b0;
        if (m_err) return;
        if (we) begin
            for (int i = 0; i < size; i++) begin
                m_mem[int'(a) + i]   = wdata[8*i +: 8];
                m_known[int'(a) + i] = 1'b1;
            end
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) begin
                if (!m_known[int'(a) + i]) m_unknown = 1'b1;
                v[8*i +: 8] = m_mem[int'(a) + i];
            end
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            m_rdata = v;
        end
    endfunction

    // Model update: sample the handshake as the DUT sees it at each edge.
    initial begin
        for (int i = 0; i < DMEM_SIZE; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_live    = 1'b1;
                m_pending = 1'b0;
            end else if (m_live) begin
                if (!m_pending) begin
                    if (bus.req_valid) begin
                        model_access(bus.req_we, bus.req_addr, bus.req_funct3, bus.req_wdata);
                        m_pending = 1'b1;
                    end
                end else if (bus.rsp_ready) begin
                    m_pending = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live && !rst) begin
                check("cmp_rsp_valid", bus.rsp_valid, m_pending);
                check("cmp_req_ready", bus.req_ready, !m_pending);
                if (m_pending) begin
                    check("cmp_rsp_err", bus.rsp_err, m_err);
                    if (!m_unknown) check("cmp_rsp_rdata", bus.rsp_rdata, m_rdata);
                end
            end
        end
    end

    // Issue one request with rsp_ready high; starts and ends just after a rising edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int budget;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rsp_latency", bus.rsp_valid, 1'b1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] held;
        vec_t        loads [5];
        vec_t        errs  [8];
        int          done;
        int          cyc;
        int          r;
        bit          accepted;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_funct3 = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset_rsp_err",   bus.rsp_err,   1'b0);
        @(posedge clk); #1;

        // Word store and readback
        do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er);
        check("sw_rdata", rd, 32'h0);
        check("sw_err",   er, 1'b0);
        do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err",   er, 1'b0);

        // Byte store then sub-word loads with extension
        do_req(1'b1, 32'h11, 3'b000, 32'h000000A5, rd, er);
        check("sb_err", er, 1'b0);
        loads[0] = '{1'b0, 32'h10, 3'b010, 32'hDEADA5EF};
        loads[1] = '{1'b0, 32'h11, 3'b000, 32'hFFFFFFA5};
        loads[2] = '{1'b0, 32'h11, 3'b100, 32'h000000A5};
        loads[3] = '{1'b0, 32'h12, 3'b001, 32'hFFFFDEAD};
        loads[4] = '{1'b0, 32'h12, 3'b101, 32'h0000DEAD};
        foreach (loads[i]) begin
            do_req(1'b0, loads[i].addr, loads[i].f3, 32'h0, rd, er);
            check($sformatf("load%0d_rdata", i), rd, loads[i].exp);
            check($sformatf("load%0d_err", i),   er, 1'b0);
        end

        // Erroring requests: misaligned, out of range, illegal funct3
        errs[0] = '{1'b0, 32'h13,                 3'b010, 32'h0};
        errs[1] = '{1'b1, 32'h21,                 3'b001, 32'h0};
        errs[2] = '{1'b1, 32'h11,                 3'b001, 32'h0};
        errs[3] = '{1'b0, 32'(DMEM_SIZE - 2),     3'b010, 32'h0};
        errs[4] = '{1'b0, 32'h10,                 3'b011, 32'h0};
        errs[5] = '{1'b1, 32'h10,                 3'b100, 32'h0};
        errs[6] = '{1'b0, 32'(DMEM_SIZE),         3'b000, 32'h0};
        errs[7] = '{1'b1, 32'(DMEM_SIZE + 32'h10), 3'b010, 32'h0};
        foreach (errs[i]) begin
            do_req(errs[i].we, errs[i].addr, errs[i].f3, 32'hFFFFFFFF, rd, er);
            check($sformatf("err%0d_err", i),   er, 1'b1);
            check($sformatf("err%0d_rdata", i), rd, 32'h0);
        end
        do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        check("after_err_lw", rd, 32'hDEADA5EF);

        // Top-of-memory boundary
        do_req(1'b1, 32'(DMEM_SIZE - 4), 3'b010, 32'hCAFEF00D, rd, er);
        check("top_sw_err", er, 1'b0);
        do_req(1'b0, 32'(DMEM_SIZE - 1), 3'b000, 32'h0, rd, er);
        check("top_lb_rdata", rd, 32'hFFFFFFCA);
        do_req(1'b0, 32'(DMEM_SIZE - 2), 3'b101, 32'h0, rd, er);
        check("top_lhu_rdata", rd, 32'h0000CAFE);

        // Backpressure: response held, second request waits
        bus.rsp_ready  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h55AA55AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            held = bus.rsp_rdata;
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rdata",     held,          32'hDEADA5EF);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_valid", bus.rsp_valid, 1'b0);
        check("bp_idle_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_store_rsp", bus.rsp_valid, 1'b1);
        @(posedge clk); #1;
        do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er);
        check("bp_store_readback", rd, 32'h55AA55AA);

        // Reset during RESP, then a store presented with reset high
        bus.rsp_ready  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rr_pending", bus.rsp_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rr_rsp_valid", bus.rsp_valid, 1'b0);
        check("rr_req_ready", bus.req_ready, 1'b1);
        check("rr_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'h12345678;
        bus.req_valid  = 1'b1;
        rst            = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_sw_not_accepted", bus.rsp_valid, 1'b0);
        @(posedge clk); #1;
        do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        check("rst_sw_readback", rd, 32'hDEADA5EF);

        // Initialise the random-stream regions so loads have known data
        for (int w = 0; w < 18; w++) do_req(1'b1, 32'(4*w), 3'b010, $urandom, rd, er);
        for (int w = 0; w < 4; w++)  do_req(1'b1, 32'(DMEM_SIZE - 16 + 4*w), 3'b010, $urandom, rd, er);

        // Random stream with random backpressure
        done = 0;
        cyc  = 0;
        while (done < 1000 && cyc < 20000) begin
            @(negedge clk);
            accepted = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            cyc++;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (accepted) begin
                done++;
                bus.req_valid = 1'b0;
            end
            if (!bus.req_valid && ($urandom_range(0, 1) == 1)) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)      bus.req_addr = 32'($urandom_range(0, 'h47));
                else if (r < 9) bus.req_addr = 32'(DMEM_SIZE - 16 + int'($urandom_range(0, 15)));
                else            bus.req_addr = $urandom;
                case ($urandom_range(0, 5))
                    0:       bus.req_funct3 = 3'b000;
                    1:       bus.req_funct3 = 3'b001;
                    2:       bus.req_funct3 = 3'b010;
                    3:       bus.req_funct3 = 3'b100;
                    4:       bus.req_funct3 = 3'b101;
                    default: bus.req_funct3 = 3'($urandom_range(0, 7));
                endcase
                bus.req_we    = 1'($urandom_range(0, 1));
                bus.req_wdata = $urandom;
                bus.req_valid = 1'b1;
            end
        end
        check("random_done", done, 1000);

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
